// File: rtl/filter_index_scheduler_pkg.sv
// Shared types and defaults for the filter index scheduler and its decoder neighbour.
package filter_index_scheduler_pkg;
    localparam int F_DEF     = 4;
    localparam int IDX_W_DEF = 4;
    localparam int DEC_LAT   = 3;

    typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/filter_index_scheduler.sv
// Feeds index groups of one layer into the index decoder, tracks the decoder
// latency and reports when the last result of the layer has left the decoder.
module filter_index_scheduler
    import filter_index_scheduler_pkg::*;
#(
    parameter int F      = F_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int SIZE_W = 6,
    parameter int GRP_W  = 12,
    parameter int LAT    = DEC_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [SIZE_W-1:0]    cfg_filter_size,
    input  logic [GRP_W-1:0]     cfg_num_groups,
    output logic                 cfg_ready,
    input  logic                 src_valid,
    input  logic [F*IDX_W-1:0]   src_index,
    output logic                 src_ready,
    output logic [F*IDX_W-1:0]   dec_index,
    output logic                 dec_en,
    output logic [SIZE_W-1:0]    dec_filter_size,
    output logic                 dec_layer_change,
    output logic                 res_valid,
    output logic                 busy,
    output logic                 layer_done
);

    state_t            state, state_nxt;
    logic [SIZE_W-1:0] size_q;
    logic [GRP_W-1:0]  count_q;
    logic [GRP_W-1:0]  issued_q;
    logic [LAT-1:0]    vld_pipe;
    logic              first_q;
    logic              zero_done_q;
    logic              cfg_take;
    logic              xfer;
    logic              pipe_empty;

    assign pipe_empty = (vld_pipe == '0);

    always_comb begin
        state_nxt = state;
        cfg_take  = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_num_groups != '0) begin
                    cfg_take  = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: state_nxt = ISSUE;
            ISSUE: begin
                xfer = src_valid;
                // issued_q never exceeds count_q-1 here, so the increment cannot wrap
                if (src_valid && (issued_q + GRP_W'(1)) == count_q)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            size_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            vld_pipe    <= '0;
            first_q     <= 1'b1;
            zero_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            first_q     <= 1'b0;
            zero_done_q <= (state == IDLE) && cfg_valid && (cfg_num_groups == '0);
            if (cfg_take) begin
                size_q   <= cfg_filter_size;
                count_q  <= cfg_num_groups;
                issued_q <= '0;
            end else if (xfer) begin
                issued_q <= issued_q + GRP_W'(1);
            end
            vld_pipe[0] <= xfer;
            for (int i = 1; i < LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Outputs are qualified by rst so the reset cycle itself shows a quiet interface.
    assign cfg_ready        = !rst || (state == IDLE);
    assign src_ready        = rst && xfer;
    assign dec_en           = rst && xfer;
    assign dec_index        = (rst && xfer) ? src_index : '0;
    assign dec_filter_size  = rst ? size_q : '0;
    assign dec_layer_change = rst && ((state == CLEAR) || first_q);
    assign res_valid        = rst && vld_pipe[LAT-1];
    assign busy             = rst && (state != IDLE);
    assign layer_done       = rst && (zero_done_q || ((state == DRAIN) && pipe_empty));

endmodule

// File: tb/tb_filter_index_scheduler.sv
// Directed bench for filter_index_scheduler with a cycle-stamped scoreboard
// for decoder results and layer completion pulses.
module tb_filter_index_scheduler;
    localparam int F = 4, IDX_W = 4, SIZE_W = 6, GRP_W = 12, LAT = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0;
    logic [SIZE_W-1:0]   cfg_filter_size = '0;
    logic [GRP_W-1:0]    cfg_num_groups = '0;
    logic                cfg_ready;
    logic                src_valid = 1'b0;
    logic [F*IDX_W-1:0]  src_index = '0;
    logic                src_ready;
    logic [F*IDX_W-1:0]  dec_index;
    logic                dec_en;
    logic [SIZE_W-1:0]   dec_filter_size;
    logic                dec_layer_change;
    logic                res_valid;
    logic                busy;
    logic                layer_done;

    filter_index_scheduler #(.F(F), .IDX_W(IDX_W), .SIZE_W(SIZE_W), .GRP_W(GRP_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_filter_size(cfg_filter_size), .cfg_num_groups(cfg_num_groups),
        .cfg_ready(cfg_ready),
        .src_valid(src_valid), .src_index(src_index), .src_ready(src_ready),
        .dec_index(dec_index), .dec_en(dec_en), .dec_filter_size(dec_filter_size),
        .dec_layer_change(dec_layer_change), .res_valid(res_valid), .busy(busy),
        .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int n_res = 0, n_done = 0;
    int res_q[$];
    int done_q[$];
    logic mon_en = 1'b0;
    logic [SIZE_W-1:0] exp_size = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard side: every result and completion pulse must match a stamped expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (res_valid) begin
                n_res++;
                if (res_q.size() == 0) check("res_unexpected", 1, 0);
                else check("res_cycle", cyc, res_q.pop_front());
            end
            if (layer_done) begin
                n_done++;
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic run_layer(input logic [SIZE_W-1:0] size, input int groups,
                             input logic [15:0] stall_mask, input bit poke);
        int sent = 0, j = 0, last = 0;
        bit v, seen = 0;
        tick();
        cfg_valid = 1'b1; cfg_filter_size = size; cfg_num_groups = GRP_W'(groups); src_valid = 1'b0;
        sample();
        check("cfg_ready_idle", cfg_ready, 1);
        check("size_before_clear", dec_filter_size, exp_size);
        tick();
        cfg_valid = 1'b0;
        sample();
        exp_size = size;
        check("clear_pulse", dec_layer_change, 1);
        check("clear_busy", busy, 1);
        check("clear_src_ready", src_ready, 0);
        check("clear_size", dec_filter_size, exp_size);
        while (sent < groups) begin
            tick();
            v = (j < 16) ? !stall_mask[j] : 1'b1;
            cfg_valid = 1'b0;
            src_valid = v;
            src_index = F*IDX_W'($urandom);
            if (poke && j == 1) begin
                cfg_valid = 1'b1; cfg_num_groups = 7; cfg_filter_size = 33;
            end
            sample();
            check("issue_en", dec_en, v);
            check("issue_index", dec_index, v ? src_index : '0);
            check("issue_src_ready", src_ready, v);
            check("issue_change", dec_layer_change, 0);
            if (j < 3 || (poke && j == 1)) begin
                check("issue_cfg_ready", cfg_ready, 0);
                check("issue_busy", busy, 1);
                check("issue_size", dec_filter_size, exp_size);
            end
            if (v) begin
                res_q.push_back(cyc + LAT);
                sent++;
                last = cyc;
            end
            j++;
        end
        tick();
        src_valid = 1'b0; cfg_valid = 1'b0;
        done_q.push_back(last + LAT + 1);
        for (int k = 0; k < LAT + 4; k++) begin
            sample();
            check("drain_src_ready", src_ready, 0);
            if (layer_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        int r0, d0;
        // reset
        tick(); tick();
        sample();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_dec_en", dec_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", layer_done, 0);
        check("rst_change", dec_layer_change, 0);
        check("rst_size", dec_filter_size, 0);
        tick();
        rst = 1'b1;
        mon_en = 1'b1;
        sample();
        check("post_rst_change", dec_layer_change, 1);
        check("post_rst_cfg_ready", cfg_ready, 1);
        tick();
        sample();
        check("post_rst_change_drop", dec_layer_change, 0);

        // basic layer, no stalls
        run_layer(9, 4, 16'h0000, 0);
        // stalls on the 2nd and 3rd ISSUE cycles
        r0 = n_res;
        run_layer(9, 5, 16'h0006, 0);
        check("stall_res_count", n_res - r0, 5);
        // configuration attempt in mid-layer is ignored
        r0 = n_res;
        run_layer(12, 4, 16'h0000, 1);
        check("poke_res_count", n_res - r0, 4);

        // zero-group configuration
        tick();
        cfg_valid = 1'b1; cfg_num_groups = 0; cfg_filter_size = 17;
        sample();
        check("zero_busy_cfg", busy, 0);
        tick();
        cfg_valid = 1'b0;
        done_q.push_back(cyc);
        sample();
        check("zero_done", layer_done, 1);
        check("zero_busy", busy, 0);
        check("zero_change", dec_layer_change, 0);
        check("zero_size_kept", dec_filter_size, exp_size);
        tick();
        sample();
        check("zero_done_drop", layer_done, 0);

        // reset in the middle of a layer after 2 of 6 groups
        tick();
        cfg_valid = 1'b1; cfg_num_groups = 6; cfg_filter_size = 9;
        sample();
        tick();
        cfg_valid = 1'b0;
        sample();
        for (int k = 0; k < 2; k++) begin
            tick();
            src_valid = 1'b1; src_index = 16'hA5A5;
            sample();
            check("mid_issue_en", dec_en, 1);
        end
        tick();
        src_valid = 1'b0; rst = 1'b0;
        sample();
        check("mid_rst_res", res_valid, 0);
        check("mid_rst_done", layer_done, 0);
        tick();
        rst = 1'b1;
        exp_size = '0;
        sample();
        check("mid_after_busy", busy, 0);
        check("mid_after_cfg_ready", cfg_ready, 1);
        check("mid_after_res", res_valid, 0);
        check("mid_after_done", layer_done, 0);
        check("mid_after_change", dec_layer_change, 1);
        check("mid_after_size", dec_filter_size, 0);
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            sample();
            check("mid_quiet_res", res_valid, 0);
        end
        run_layer(5, 3, 16'h0000, 0);

        // back-to-back layers
        r0 = n_res; d0 = n_done;
        run_layer(9, 2, 16'h0000, 0);
        run_layer(25, 3, 16'h0000, 0);
        check("b2b_res_count", n_res - r0, 5);
        check("b2b_done_count", n_done - d0, 2);

        // largest group count completes without wrapping
        r0 = n_res;
        run_layer(63, 4095, 16'h0000, 0);
        check("max_res_count", n_res - r0, 4095);

        tick(); tick();
        sample();
        check("res_q_empty", res_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/filter_index_scheduler.md
FILTER_INDEX_SCHEDULER -- requirements
Module: filter_index_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- F, 4: index lanes per group.
- IDX_W, 4: bits per index lane.
- SIZE_W, 6: filter-size field width.
- GRP_W, 12: group-count width.
- LAT, 3: decoder index-to-result latency in cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: one clock; reset is synchronous and active-low.
- cfg_valid, in, 1: layer configuration strobe.
- cfg_filter_size, in, SIZE_W: R*S of the new layer.
- cfg_num_groups, in, GRP_W: F-wide index groups in the layer.
- cfg_ready, out, 1: configuration accepted when high with cfg_valid.
- src_valid, in, 1: index group available from buffer.
- src_index, in, F*IDX_W: index group.
- src_ready, out, 1: group consumed this cycle.
- dec_index, out, F*IDX_W: index vector to decoder.
- dec_en, out, 1: decoder advances its running state this cycle.
- dec_filter_size, out, SIZE_W: latched layer filter size.
- dec_layer_change, out, 1: decoder state-clear pulse.
- res_valid, out, 1: decoder results for an issued group present this cycle.
- busy, out, 1: layer in progress.
- layer_done, out, 1: one-cycle pulse after the last result.

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, ISSUE and DRAIN.
REQ-004 IDLE SHALL drive cfg_ready=1. cfg_valid with cfg_num_groups>0 SHALL latch size and count, then go to CLEAR.
REQ-005 cfg_valid with cfg_num_groups=0 SHALL stay in IDLE and pulse layer_done the next cycle.
REQ-006 CLEAR SHALL last exactly one cycle, assert dec_layer_change=1, then go to ISSUE.
REQ-007 In ISSUE, src_ready SHALL equal src_valid combinationally, and the transfer rule SHALL be:
- src_valid=1: one transfer.
- dec_index SHALL equal src_index.
- dec_en=1.
- The issued counter SHALL increment.
REQ-008 When src_valid=0 in ISSUE, dec_en SHALL be 0 and dec_index SHALL be zero. A stall SHALL NOT advance the decoder.
REQ-009 The transfer that makes issued equal the latched count SHALL move the FSM to DRAIN on the next cycle. src_ready SHALL be 0 outside ISSUE.
REQ-010 res_valid SHALL be dec_en delayed by exactly LAT cycles through a LAT-deep shift register. Stall bubbles SHALL propagate as res_valid=0.
REQ-011 DRAIN SHALL wait until the shift register is all-zero, then pulse layer_done for one cycle and return to IDLE.
REQ-012 The number of res_valid cycles per layer SHALL equal cfg_num_groups exactly.
REQ-013 cfg_ready SHALL be 0 outside IDLE. cfg_valid outside IDLE SHALL be ignored with no state change.
REQ-014 dec_filter_size SHALL hold the latched value from configuration until the next accepted configuration.
REQ-015 busy SHALL be 1 in CLEAR, ISSUE and DRAIN, and 0 in IDLE.
REQ-016 Counters SHALL be GRP_W wide and SHALL NOT wrap. A group count of 2^GRP_W-1 SHALL complete normally.
REQ-017 Back-to-back layers: configuration SHALL be accepted in the IDLE cycle that immediately follows the layer_done cycle.

Reset
REQ-018 rst=0 at a clock edge SHALL force IDLE, clear counters and the shift register, and clear the latched size and count.
REQ-019 Reset SHALL drive all outputs to 0 except cfg_ready=1. dec_layer_change SHALL be 1 for the first cycle after reset release so the decoder starts clean.
REQ-020 Reset asserted mid-layer SHALL abandon the layer with no layer_done pulse.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state enum (IDLE, CLEAR, ISSUE, DRAIN);
- LAT as the decoder-latency constant;
- the F and IDX_W defaults.
REQ-022 The block SHALL be a single module containing the FSM, the counters and the latency shift register. No sub-module is required.
REQ-023 The block SHALL be instantiated beside the index decoder, driving its index, filter-size and layer-change inputs. dec_en SHALL gate the decoder's running-state update.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Config size=9, groups=4, src_valid held high: CLEAR for 1 cycle; dec_en=1 for 4 consecutive cycles; res_valid for 4 cycles starting LAT after the first issue; layer_done at the expected cycle.
- Groups=5 with src_valid low on cycles 2 and 3 of ISSUE: dec_en pattern 1,0,0,1,1,1,1; exactly 5 res_valid; no decoder advance during stall cycles.
- cfg_valid pulsed during ISSUE with groups=7: ignored; cfg_ready=0; the original layer completes with its own count.
- cfg_num_groups=0: no CLEAR; layer_done pulses the next cycle; busy stays 0.
- Reset mid-ISSUE after 2 of 6 groups: next cycle IDLE, res_valid=0, no layer_done; a new layer with groups=3 then runs cleanly.
- Two back-to-back layers (groups 2, then 3, sizes 9 and 25): dec_filter_size switches only at the second CLEAR; 5 res_valid in total; 2 layer_done pulses.
